// File: rtl/proc_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle instruction sequencer.
package proc_pkg;

    localparam int OPCODE_W = 11;
    localparam int INSTR_W  = 32;
    localparam int PC_INCR  = 4;
    localparam int BR_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_e;

endpackage

// File: rtl/instr_sequencer_wait_timer.sv
// Saturating wait counter for memory handshakes; expired flags that one more
// idle cycle would reach LIMIT consecutive cycles without ready.
module wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle LEGv8 sequencer: owns the PC, fetches into an instruction
// register, waits on imem/dmem handshakes and gates write enables on commit.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 64,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [INSTR_W-1:0]   instr,
    output logic [OPCODE_W-1:0]  opcode,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    input  logic                 uncond_branch,
    input  logic                 cond_branch,
    input  logic                 alu_zero,
    input  logic [PC_WIDTH-1:0]  branch_offset,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ready,
    output logic                 reg_we,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 retired,
    output logic                 busy,
    output logic                 fault
);

    seq_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;

    logic                 tmr_clr, tmr_inc, tmr_expired;
    logic                 commit;
    logic                 br_taken;
    logic [PC_WIDTH-1:0]  next_pc;

    wait_timer #(
        .LIMIT   (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    // Offsets are in words; all arithmetic wraps modulo 2^PC_WIDTH.
    assign br_taken = uncond_branch | (cond_branch & alu_zero);
    assign next_pc  = pc_q + (br_taken ? (branch_offset << BR_SHIFT)
                                       : PC_WIDTH'(PC_INCR));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        retired  = 1'b0;
        commit   = 1'b0;
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                    tmr_clr = 1'b1;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_data;
                    state_d = ST_EXEC;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_EXEC: begin
                if (mem_read && mem_write) begin
                    state_d = ST_FAULT;
                end else if (mem_read || mem_write) begin
                    state_d = ST_MEM;
                    tmr_clr = 1'b1;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready) begin
                    commit = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A dropped run lets the current instruction finish, then parks in IDLE.
        if (commit) begin
            reg_we  = reg_write;
            retired = 1'b1;
            pc_d    = next_pc;
            if (run) begin
                state_d = ST_FETCH;
                tmr_clr = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc     = pc_q;
    assign instr  = instr_q;
    assign opcode = instr_q[INSTR_W-1 -: OPCODE_W];
    assign busy   = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MEM);
    assign fault  = (state_q == ST_FAULT);

endmodule
